// File: rtl/sm_egress_reader_pkg.sv
// Shared switch definitions: FSM state encodings, data width and descriptor field widths.
// Used by both the ingress write path and the egress reader.
package sm_egress_reader_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;
  localparam int LEN_WIDTH  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sm_egress_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head word whenever !empty.
// Writers must not push when full; the egress credit scheme guarantees this.
module sm_egress_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_ok;

  assign empty  = (count_reg == '0);
  assign count  = count_reg;
  assign pop_ok = pop && !empty;
  // Storage is not reset, so mask the head until something has been written.
  assign dout   = empty ? '0 : mem_q[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sm_egress_reader.sv
// Egress reader: fetches a packet from shared memory and streams it on one tx port.
// Optional EGRESS_PKT_CNT_EN adds a 16-bit wrapping count of transmitted packets.
module sm_egress_reader #(
  parameter int DATA_WIDTH = sm_egress_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sm_egress_reader_pkg::ADDR_WIDTH,
  parameter int LEN_WIDTH  = sm_egress_reader_pkg::LEN_WIDTH,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_sop,
  output logic                  tx_eop,
  output logic                  free_valid,
  output logic [ADDR_WIDTH-1:0] free_addr
`ifdef EGRESS_PKT_CNT_EN
  ,
  output logic [15:0]           tx_pkt_cnt
`endif
);

  import sm_egress_reader_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 8;

  state_e                state_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  issued_reg;
  logic [RD_LAT-1:0]     pipe_vld_reg;
  logic [RD_LAT-1:0]     pipe_sop_reg;
  logic [RD_LAT-1:0]     pipe_eop_reg;

  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [DATA_WIDTH+1:0]   fifo_dout;
  logic [OW-1:0]           inflight;
  logic [OW-1:0]           occupancy;
  logic                    rd_fire;
  logic                    rd_last;
  logic                    tx_fire;
  logic                    eop_fire;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OW'(pipe_vld_reg[i]);
    end
  end

  // Reads in flight reserve FIFO space, so the FIFO can never overflow.
  assign occupancy   = OW'(fifo_count) + inflight;
  assign rd_fire     = (state_reg == ST_READ) && (occupancy < OW'(FIFO_DEPTH));
  assign rd_last     = ((issued_reg + LEN_WIDTH'(1)) == len_reg);
  assign mem_rd_en   = rd_fire;
  assign mem_rd_addr = base_reg + ADDR_WIDTH'(issued_reg);
  assign desc_ready  = (state_reg == ST_IDLE);

  assign tx_valid = !fifo_empty;
  assign {tx_sop, tx_eop, tx_data} = fifo_dout;
  assign tx_fire  = tx_valid && tx_ready;
  assign eop_fire = tx_fire && tx_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      base_reg   <= '0;
      len_reg    <= '0;
      issued_reg <= '0;
      free_valid <= 1'b0;
      free_addr  <= '0;
    end else begin
      free_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (desc_valid) begin
            base_reg   <= desc_addr;
            len_reg    <= desc_len;
            issued_reg <= '0;
            state_reg  <= (desc_len == '0) ? ST_DRAIN : ST_READ;
          end
        end
        ST_READ: begin
          if (rd_fire) begin
            issued_reg <= issued_reg + LEN_WIDTH'(1);
            if (rd_last) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((len_reg == '0) || eop_fire) begin
            free_valid <= 1'b1;
            free_addr  <= base_reg;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Tracking pipe mirrors the memory latency so framing meets its data at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_reg <= '0;
      pipe_sop_reg <= '0;
      pipe_eop_reg <= '0;
    end else begin
      pipe_vld_reg[0] <= rd_fire;
      pipe_sop_reg[0] <= (issued_reg == '0);
      pipe_eop_reg[0] <= rd_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_reg[i] <= pipe_vld_reg[i-1];
        pipe_sop_reg[i] <= pipe_sop_reg[i-1];
        pipe_eop_reg[i] <= pipe_eop_reg[i-1];
      end
    end
  end

  sm_egress_fifo #(
    .W     (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pipe_vld_reg[RD_LAT-1]),
    .din   ({pipe_sop_reg[RD_LAT-1], pipe_eop_reg[RD_LAT-1], mem_rd_data}),
    .pop   (tx_fire),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef EGRESS_PKT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_pkt_cnt <= '0;
    end else if (eop_fire) begin
      tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sm_egress_reader.sv
// Scoreboard bench for sm_egress_reader with a 2-cycle-latency memory model.
module tb_sm_egress_reader;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int LW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic [AW-1:0] desc_addr = '0;
  logic [LW-1:0] desc_len = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [DW-1:0] tx_data;
  logic          tx_sop;
  logic          tx_eop;
  logic          free_valid;
  logic [AW-1:0] free_addr;
`ifdef EGRESS_PKT_CNT_EN
  logic [15:0]   tx_pkt_cnt;
`endif

  always #5 clk = ~clk;

  sm_egress_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .RD_LAT     (2),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_addr   (desc_addr),
    .desc_len    (desc_len),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_sop      (tx_sop),
    .tx_eop      (tx_eop),
    .free_valid  (free_valid),
    .free_addr   (free_addr)
`ifdef EGRESS_PKT_CNT_EN
    ,
    .tx_pkt_cnt  (tx_pkt_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    logic [15:0] t;
    t = {6'b0, a};
    return (t * 16'd37) ^ 16'h5A3C;
  endfunction

  // Memory model: data appears two cycles after the read strobe; never reset.
  logic [DW-1:0] rdp0, rdp1;
  always @(posedge clk) begin
    rdp0 <= mem_rd_en ? mem_word(mem_rd_addr) : 16'hDEAD;
    rdp1 <= rdp0;
  end
  assign mem_rd_data = rdp1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]   rdq[$];
  logic [DW+1:0]   txq[$];
  logic [AW-1:0]   freeq[$];
  int              outstanding = 0;
  int              rd_cnt = 0;
  int              tx_cnt = 0;
  int              acc = 0;
  int              first_rd = -1;
  int              first_tx = -1;
  int              free_cyc = -1;
  logic [15:0]     exp_pkt = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
`ifdef EGRESS_PKT_CNT_EN
        if (free_valid) chk("pkt_cnt", 32'(tx_pkt_cnt), 32'(exp_pkt));
`endif
        if (mem_rd_en) begin
          chk("credit", 32'(outstanding < DEPTH), 32'd1);
          if (rdq.size() > 0) chk("rd_addr", 32'(mem_rd_addr), 32'(rdq.pop_front()));
          else chk("rd_spurious", 32'(rdq.size()), 32'd1);
          outstanding++;
          rd_cnt++;
          if (first_rd < 0) first_rd = cyc;
        end
        if (tx_valid) begin
          if (first_tx < 0) first_tx = cyc;
          if (txq.size() > 0) begin
            chk("tx_word", 32'({tx_sop, tx_eop, tx_data}), 32'(txq[0]));
            if (tx_ready) void'(txq.pop_front());
          end else begin
            chk("tx_spurious", 32'(txq.size()), 32'd1);
          end
          if (tx_ready) begin
            outstanding--;
            tx_cnt++;
            $display("tx word data=0x%04h sop=%0d eop=%0d", tx_data, tx_sop, tx_eop);
            if (tx_eop) exp_pkt = exp_pkt + 16'd1;
          end
        end
        if (free_valid) begin
          free_cyc = cyc;
          if (freeq.size() > 0) chk("free_addr", 32'(free_addr), 32'(freeq.pop_front()));
          else chk("free_spurious", 32'(freeq.size()), 32'd1);
        end
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n;
    logic [AW-1:0] ad;
    n = 0;
    @(posedge clk);
    #1;
    desc_valid = 1'b1;
    desc_addr  = a;
    desc_len   = l;
    do begin
      @(negedge clk);
      n++;
    end while (!desc_ready && n < 50);
    chk("desc_accept", 32'(desc_ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc - 1;
    desc_valid = 1'b0;
    first_rd = -1;
    first_tx = -1;
    free_cyc = -1;
    for (int i = 0; i < int'(l); i++) begin
      ad = a + AW'(i);
      rdq.push_back(ad);
      txq.push_back({(i == 0), (i == int'(l) - 1), mem_word(ad)});
    end
    freeq.push_back(a);
    $display("desc addr=0x%03h len=%0d accepted at cyc=%0d", a, l, acc);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((freeq.size() + txq.size() + rdq.size()) != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pkt_done", 32'(freeq.size() + txq.size() + rdq.size()), 32'd0);
    chk("desc_ready_idle", 32'(desc_ready), 32'd1);
  endtask

  int rc0, tc0, n6;

  initial begin
    #1;
    chk("rst_desc_ready", 32'(desc_ready), 32'd1);
    chk("rst_outputs", 32'({mem_rd_en, tx_valid, tx_sop, tx_eop, free_valid}), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_free_addr", 32'(free_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: basic packet, latency checks
    send(10'h010, 6'd4);
    wait_done();
    chk("lat_first_rd", 32'(first_rd - acc), 32'd1);
    chk("lat_first_tx", 32'(first_tx - acc), 32'd4);
    chk("lat_free", 32'(free_cyc - acc), 32'd8);

    // 2: backpressure during cycles 5-10
    send(10'h020, 6'd8);
    repeat (4) @(posedge clk);
    #1 tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 chk("fill_stall", 32'(outstanding), 32'd4);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done();

    // 3: address wrap
    send(10'h3FE, 6'd4);
    wait_done();

    // 4: single-word packet
    send(10'h055, 6'd1);
    wait_done();

    // 5: zero-length packet
    rc0 = rd_cnt;
    tc0 = tx_cnt;
    send(10'h077, 6'd0);
    wait_done();
    chk("len0_no_reads", 32'(rd_cnt - rc0), 32'd0);
    chk("len0_no_tx", 32'(tx_cnt - tc0), 32'd0);

    // 6: reset mid-packet, then a clean packet
    tc0 = tx_cnt;
    send(10'h200, 6'd6);
    n6 = 0;
    while ((tx_cnt - tc0) < 2 && n6 < 50) begin
      @(negedge clk);
      #1;
      n6++;
    end
    chk("mid_pkt_progress", 32'((tx_cnt - tc0) >= 2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_desc_ready", 32'(desc_ready), 32'd1);
    chk("midrst_outputs", 32'({mem_rd_en, tx_valid, free_valid}), 32'd0);
    rdq.delete();
    txq.delete();
    freeq.delete();
    outstanding = 0;
    exp_pkt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send(10'h100, 6'd3);
    wait_done();

    // 7: random backpressure
    send(10'h0A0, 6'd9);
    for (int i = 0; i < 200 && (txq.size() + freeq.size()) != 0; i++) begin
      @(posedge clk);
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
